// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the reg4 write arbiter.
// The LOCKED state is only reachable when REG_ARB_LOCK_EN is defined.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 4;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PTR_W = ptr_width(N_REQ_DEF);

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first eligible request after ptr, wrapping.
module rr_select #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [N_REQ-1:0] elig;
  logic [PW:0]      pos;

  always_comb begin
    elig  = req & mask;
    pick  = '0;
    valid = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      // ptr < N_REQ and k <= N_REQ, so one subtraction is enough to wrap
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N_REQ)) pos = pos - (PW+1)'(N_REQ);
      if (!valid && elig[pos[PW-1:0]]) begin
        pick[pos[PW-1:0]] = 1'b1;
        valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg4_write_arbiter.sv
// Round-robin write arbiter owning a shared enable register.
// Optional ownership lock enabled by defining REG_ARB_LOCK_EN.
module reg4_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] WDATA,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       LOCK,
`endif
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       ACK,
  output logic [WIDTH-1:0]       Q,
  output logic                   BUSY
);

  localparam int unsigned PW = ptr_width(N_REQ);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    own_q, own_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q;
  logic             q_we;
  logic [WIDTH-1:0] q_wd;

  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic             req_own;
  logic             lock_own;

  rr_select #(.N_REQ(N_REQ), .PW(PW)) u_rr_select (
    .req   (REQ),
    .mask  (~ack_q),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // gnt_q is one-hot on the owner outside IDLE, so it doubles as the select
  assign req_own = |(REQ & gnt_q);
`ifdef REG_ARB_LOCK_EN
  assign lock_own = |(LOCK & gnt_q);
`else
  assign lock_own = 1'b0;
`endif

  always_comb begin
    pick_idx = '0;
    q_wd     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i])  pick_idx = PW'(i);
      if (gnt_q[i]) q_wd     = WDATA[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_WRITE;
          gnt_d   = pick;
          own_d   = pick_idx;
        end
      end
      ST_WRITE: begin
        if (req_own) begin
          q_we  = 1'b1;
          ack_d = gnt_q;
          ptr_d = own_q;
        end
        if (lock_own) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
`ifdef REG_ARB_LOCK_EN
      ST_LOCKED: begin
        if (req_own && !(|(ack_q & gnt_q))) begin
          state_d = ST_WRITE;
        end else if (!req_own && !lock_own) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      own_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)  q_q <= '0;
    else if (q_we) q_q <= q_wd;
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign Q    = q_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Scoreboard bench for reg4_write_arbiter: directed plan plus random traffic.
// Lock scenarios are exercised when REG_ARB_LOCK_EN is defined.
module tb_reg4_write_arbiter;

  logic        CLOCK;
  logic        RESET_N;
  logic [3:0]  REQ;
  logic [15:0] WDATA;
  logic [3:0]  LOCK;
  logic [3:0]  GNT;
  logic [3:0]  ACK;
  logic [3:0]  Q;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  // expected {GNT, ACK, Q, BUSY} after each rising edge
  logic [12:0] exp_q[$];

  // reference model: 0 = idle, 1 = writing, 2 = locked owner
  int         m_state;
  int         m_own;
  int         m_ptr;
  logic [3:0] m_gnt;
  logic [3:0] m_ack;
  logic [3:0] m_q;

  reg4_write_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .REQ     (REQ),
    .WDATA   (WDATA),
`ifdef REG_ARB_LOCK_EN
    .LOCK    (LOCK),
`endif
    .GNT     (GNT),
    .ACK     (ACK),
    .Q       (Q),
    .BUSY    (BUSY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic model_step(input logic rst, input logic [3:0] r,
                            input logic [3:0] lk, input logic [15:0] d);
    int w;
    if (rst) begin
      m_state = 0; m_ptr = 3; m_own = 0;
      m_gnt = '0; m_ack = '0; m_q = '0;
    end else if (m_state == 0) begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && r[i] && !m_ack[i]) w = i;
      end
      m_ack = '0;
      if (w >= 0) begin
        m_state = 1; m_own = w;
        m_gnt = '0; m_gnt[w] = 1'b1;
      end
    end else if (m_state == 1) begin
      m_ack = '0;
      if (r[m_own]) begin
        m_q = d[m_own*4 +: 4];
        m_ack[m_own] = 1'b1;
        m_ptr = m_own;
      end
      if (lk[m_own]) m_state = 2;
      else begin m_state = 0; m_gnt = '0; end
    end else begin
      if (r[m_own] && !m_ack[m_own]) m_state = 1;
      else if (!r[m_own] && !lk[m_own]) begin m_state = 0; m_gnt = '0; end
      m_ack = '0;
    end
    exp_q.push_back({m_gnt, m_ack, m_q, (m_state != 0)});
  endtask

  task automatic step(input logic rst, input logic [3:0] r,
                      input logic [3:0] lk, input logic [15:0] d);
    @(negedge CLOCK);
    RESET_N = !rst; REQ = r; LOCK = lk; WDATA = d;
    model_step(rst, r, lk, d);
  endtask

  task automatic settle();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, '0, '0, '0);
  endtask

  // monitor: every cycle the DUT presents outputs, compare with the oldest expectation
  initial begin
    logic [12:0] e;
    forever begin
      @(posedge CLOCK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({GNT, ACK, Q, BUSY} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t gnt=%b/%b ack=%b/%b q=%h/%h busy=%b/%b (got/expected)",
                   $time, GNT, e[12:9], ACK, e[8:5], Q, e[4:1], BUSY, e[0]);
        end
      end
    end
  end

  task automatic run_random(input int cycles);
    logic [3:0]  r;
    logic [3:0]  lk;
    logic [15:0] d;
    for (int c = 0; c < cycles; c++) begin
      r = REQ; d = WDATA; lk = '0;
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) begin
          if ($urandom_range(2) == 0) begin r[i] = 1'b1; d[i*4 +: 4] = 4'($urandom); end
        end else if (m_ack[i]) begin
          if ($urandom_range(3) != 0) r[i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          r[i] = 1'b0;
        end
      end
`ifdef REG_ARB_LOCK_EN
      lk = LOCK;
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) lk[i] = !lk[i];
`endif
      step(1'b0, r, lk, d);
    end
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    RESET_N = 1'b0; REQ = '0; LOCK = '0; WDATA = '0;

    // reset state
    do_reset();
    settle();
    chk("reset_gnt", GNT, 0);
    chk("reset_ack", ACK, 0);
    chk("reset_q", Q, 0);
    chk("reset_busy", BUSY, 0);

    // single request from requester 2
    step(1'b0, 4'b0100, '0, 16'h0A00); settle();
    chk("single_gnt", GNT, 4'b0100);
    chk("single_busy_hi", BUSY, 1);
    step(1'b0, 4'b0100, '0, 16'h0A00); settle();
    chk("single_q", Q, 4'hA);
    chk("single_ack", ACK, 4'b0100);
    chk("single_busy_lo", BUSY, 0);
    step(1'b0, 4'b0000, '0, 16'h0A00);

    // all four requesting: rotation 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b1111, '0, 16'h4321); settle();
      for (int i = 0; i < 4; i++) if (ACK[i]) order.push_back(i);
    end
    exp_order = '{0, 1, 2, 3, 0};
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", order[i], exp_order[i]);
    step(1'b0, 4'b0000, '0, '0);

    // cancelled write leaves Q and pointer alone
    do_reset();
    step(1'b0, 4'b0010, '0, 16'h0050);
    step(1'b0, 4'b0000, '0, 16'h0050); settle();
    chk("cancel_ack", ACK, 0);
    chk("cancel_q", Q, 0);
    step(1'b0, 4'b0011, '0, 16'h0050); settle();
    chk("cancel_next_gnt", GNT, 4'b0001);
    step(1'b0, 4'b0000, '0, 16'h0050);

    // async reset in the middle of a write
    do_reset();
    step(1'b0, 4'b0001, '0, 16'h0007);
    step(1'b0, 4'b0001, '0, 16'h0007);
    step(1'b0, 4'b0000, '0, 16'h0007); settle();
    chk("pre_reset_q", Q, 4'h7);
    step(1'b0, 4'b0100, '0, 16'h0307);
    step(1'b1, 4'b0100, '0, 16'h0307);
    #1;
    chk("midrst_q", Q, 0);
    chk("midrst_gnt", GNT, 0);
    chk("midrst_ack", ACK, 0);
    chk("midrst_busy", BUSY, 0);
    step(1'b1, 4'b0100, '0, 16'h0307);
    step(1'b0, 4'b0101, '0, 16'h0307); settle();
    chk("postrst_gnt", GNT, 4'b0001);
    step(1'b0, 4'b0000, '0, '0);

    // requester 3 holds REQ through its ACK while 0 waits
    do_reset();
    step(1'b0, 4'b1000, '0, 16'hB00C);
    step(1'b0, 4'b1001, '0, 16'hB00C);
    step(1'b0, 4'b1001, '0, 16'hB00C); settle();
    chk("hold_gnt0", GNT, 4'b0001);
    step(1'b0, 4'b1001, '0, 16'hB00C);
    step(1'b0, 4'b1001, '0, 16'hB00C); settle();
    chk("hold_gnt3", GNT, 4'b1000);
    step(1'b0, 4'b0000, '0, 16'hB00C);

`ifdef REG_ARB_LOCK_EN
    // locked owner writes twice before requester 0 is served
    do_reset();
    step(1'b0, 4'b0010, 4'b0010, 16'h0060);
    step(1'b0, 4'b0011, 4'b0010, 16'h0060); settle();
    chk("lock_q6", Q, 4'h6);
    step(1'b0, 4'b0001, 4'b0010, 16'h0090);
    step(1'b0, 4'b0011, 4'b0010, 16'h0090);
    step(1'b0, 4'b0011, 4'b0010, 16'h0090);
    step(1'b0, 4'b0001, 4'b0000, 16'h0090); settle();
    chk("lock_q9", Q, 4'h9);
    chk("lock_release_gnt", GNT, 4'b0000);
    step(1'b0, 4'b0001, 4'b0000, 16'h0090); settle();
    chk("lock_then_gnt0", GNT, 4'b0001);
    step(1'b0, 4'b0000, 4'b0000, '0);
`endif

    // random traffic against the reference model
    do_reset();
    run_random(3000);
    step(1'b0, 4'b0000, '0, WDATA);
    settle();
    chk("final_q", Q, m_q);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg4_write_arbiter.md
# reg4_write_arbiter

Round-robin write arbiter and owner for a shared 4-bit enable register. Up to four requesters raise REQ with their data; the block grants one at a time, performs the register write, and returns a one-cycle ACK. It sits between independent control blocks and the single shared register, so that no requester drives the register's enable or data directly.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, register width in bits

- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  N_REQ  write request per requester; level, held until ACK
- WDATA  in  N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]; stable while REQ[i] high
- LOCK  in  N_REQ  hold ownership after write (present only with REG_ARB_LOCK_EN)
- GNT  out  N_REQ  one-hot registered grant; all zero when idle
- ACK  out  N_REQ  one-cycle pulse: write by requester i has landed in Q
- Q  out  WIDTH  current register contents
- BUSY  out  1  high in any state other than IDLE

## Operation
- Reset (async, RESET_N low): GNT=0, ACK=0, Q=0, BUSY=0, state=IDLE, pointer=N_REQ-1 (requester 0 wins first). Reset mid-write abandons the write; Q returns to 0.
- States: IDLE, WRITE, LOCKED (LOCKED only with macro).
- IDLE: if any eligible REQ, pick first requester searching pointer+1, pointer+2, ... modulo N_REQ; next state WRITE, GNT[i]=1. None eligible: stay IDLE.
- Eligible: REQ[i] high and ACK[i] low (the requester being acked this cycle is masked, so it has one cycle to drop REQ).
- WRITE: register enable high with D=WDATA[i]. At the closing edge: Q<=WDATA[i], ACK[i]<=1, GNT<=0, pointer<=i, next state IDLE (or LOCKED, see Configuration).
- REQ[i] low during WRITE: write cancelled at that edge, Q unchanged, no ACK, pointer unchanged, back to IDLE.
- Q changes only on a completed write; never otherwise.
- ACK is never high for more than one requester or more than one cycle.

## Timing
- REQ[i] first high in IDLE cycle T: GNT[i] high in T+1; Q updated and ACK[i] high in T+2.
- ACK cycle is an IDLE cycle and arbitrates: a second waiting requester gets GNT in T+3, Q in T+4. Sustained throughput one write per 2 cycles.
- Single requester repeating: must drop REQ in ACK cycle or it is re-arbitrated from T+3.
- BUSY high in T+1 (and LOCKED cycles); low in ACK cycle.

## Configuration
- REG_ARB_LOCK_EN defined: LOCK port exists. At the WRITE closing edge, if LOCK[i] high, next state LOCKED with GNT[i] held high, ACK[i] pulses as normal. In LOCKED: other requesters ignored; REQ[i] high (after the ACK cycle) -> WRITE next cycle, no arbitration; REQ[i] and LOCK[i] both low -> IDLE, GNT cleared. Cancelled write from a locked owner returns to LOCKED if LOCK[i] still high.
- Not defined: no LOCK port, no LOCKED state; every write is followed by IDLE arbitration.

## Structure
- Package reg_arb_pkg: state enumeration (IDLE, WRITE, LOCKED), default N_REQ/WIDTH constants, pointer width constant.
- One sub-module rr_select: combinational round-robin picker (request vector, pointer, eligibility mask in; one-hot pick and valid out).
- Q is held in an internal enable register written only in WRITE.

## Test plan
- Reset then REQ[2]=1, WDATA[2]=4'hA -> GNT=4'b0100 at T+1, Q=4'hA and ACK=4'b0100 at T+2, BUSY low at T+2.
- REQ=4'b1111 held, data 1,2,3,4 per requester -> grant order 0,1,2,3,0, Q sequence 1,2,3,4, one write every 2 cycles.
- REQ[1] with data 5, dropped during WRITE -> no ACK, Q stays 0, pointer unchanged (next REQ=4'b0011 grants 0 first).
- Assert RESET_N low during WRITE with Q=4'h7 -> Q, GNT, ACK, BUSY all 0 immediately; first grant after release goes to requester 0.
- REQ[3] held through ACK with REQ[0] also pending -> requester 0 granted at T+3, requester 3 after it.
- With REG_ARB_LOCK_EN: LOCK[1]=1, writes 6 then 9 from requester 1 while REQ[0] high -> both writes complete before requester 0 granted; releasing LOCK[1] and REQ[1] returns to IDLE, then GNT[0].
